// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction at a time, resolves conditional
// jumps through the external arithmetic stage and hands ordinary instructions to execute.
module pc_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       imem_ack,
  input  logic [8:0] instr,
  input  logic       reg_zero,
  input  logic [7:0] arith_res,
  output logic [7:0] pc,
  output logic       imem_req,
  output logic [7:0] arith_x,
  output logic [2:0] arith_v,
  output logic       arith_jizr,
  output logic       arith_jnzr,
  output logic [8:0] instr_out,
  output logic       instr_valid,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;

  state_t     state, state_next;
  logic [7:0] pc_next;
  logic [8:0] instr_q, instr_next;
  logic       is_jizr, is_jnzr, is_halt;

  function automatic logic [7:0] pc_inc(input logic [7:0] p);
    return p + 8'd1;
  endfunction

  assign is_jizr   = (instr_q[8:6] == 3'b110);
  assign is_jnzr   = (instr_q[8:6] == 3'b111);
  assign is_halt   = (instr_q == 9'h000);
  assign arith_x   = pc;
  assign arith_v   = instr_q[2:0];
  assign instr_out = instr_q;

  // Control outputs are decoded from state so reset clears them without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= 8'h00;
      instr_q <= 9'h000;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      instr_q <= instr_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    instr_next  = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    done        = 1'b0;
    arith_jizr  = 1'b0;
    arith_jnzr  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pc_next    = 8'h00;
          state_next = FETCH;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_next = instr;
          state_next = EXEC;
        end
      end
      EXEC: begin
        arith_jizr = is_jizr;
        arith_jnzr = is_jnzr;
        state_next = FETCH;
        if (is_jizr || is_jnzr) begin
          // Taken target comes back already wrapped from the arithmetic stage.
          if ((is_jizr && reg_zero) || (is_jnzr && !reg_zero))
            pc_next = arith_res;
          else
            pc_next = pc_inc(pc);
        end else if (is_halt) begin
          state_next = HALTED;
        end else begin
          instr_valid = 1'b1;
          pc_next     = pc_inc(pc);
        end
      end
      HALTED: begin
        done = 1'b1;
        if (start) begin
          pc_next    = 8'h00;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer, checked against an instruction-level model of the
// program counter (one call per fetched instruction).
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       imem_ack = 1'b0;
  logic [8:0] instr = 9'h000;
  logic       reg_zero = 1'b0;
  logic [7:0] arith_res = 8'h00;
  logic [7:0] pc;
  logic       imem_req;
  logic [7:0] arith_x;
  logic [2:0] arith_v;
  logic       arith_jizr;
  logic       arith_jnzr;
  logic [8:0] instr_out;
  logic       instr_valid;
  logic       done;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] mpc = 8'h00;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .imem_ack(imem_ack), .instr(instr),
    .reg_zero(reg_zero), .arith_res(arith_res), .pc(pc), .imem_req(imem_req),
    .arith_x(arith_x), .arith_v(arith_v), .arith_jizr(arith_jizr),
    .arith_jnzr(arith_jnzr), .instr_out(instr_out), .instr_valid(instr_valid),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] gen(input int kind);
    logic [8:0] x;
    case (kind)
      0: begin
        x = 9'($urandom);
        while (x == 9'h000 || x[8:7] == 2'b11) x = 9'($urandom);
      end
      1: x = {3'b110, 6'($urandom)};
      2: x = {3'b111, 6'($urandom)};
      default: x = 9'h000;
    endcase
    return x;
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    mpc = 8'h00;
    check_eq("start_pc", 32'(pc), 32'(mpc));
    check_eq("start_req", 32'(imem_req), 1);
    check_eq("start_done", 32'(done), 0);
  endtask

  // One instruction: dly cycles without ack, one fetch cycle with ack, one execute cycle.
  task automatic run_instr(input logic [8:0] ins, input logic rz, input int dly);
    logic [2:0] v;
    logic       jz, jn, hlt, taken;
    logic [7:0] tgt;
    v     = ins[2:0];
    jz    = (ins[8:6] == 3'b110);
    jn    = (ins[8:6] == 3'b111);
    hlt   = (ins == 9'h000);
    taken = (jz && rz) || (jn && !rz);
    tgt   = 8'((int'(mpc) + 2 * int'(v)) % 256);
    for (int i = 0; i < dly; i++) begin
      imem_ack = 1'b0;
      instr    = 9'($urandom);
      start    = 1'($urandom);
      reg_zero = 1'($urandom);
      @(negedge clk);
      check_eq("wait_req", 32'(imem_req), 1);
      check_eq("wait_pc", 32'(pc), 32'(mpc));
      check_eq("wait_valid", 32'(instr_valid), 0);
      tick();
    end
    imem_ack = 1'b1;
    instr    = ins;
    start    = 1'($urandom);
    @(negedge clk);
    check_eq("fetch_req", 32'(imem_req), 1);
    check_eq("fetch_pc", 32'(pc), 32'(mpc));
    tick();
    imem_ack  = 1'($urandom);
    instr     = 9'($urandom);
    reg_zero  = rz;
    arith_res = tgt;
    start     = 1'($urandom);
    @(negedge clk);
    check_eq("exec_valid", 32'(instr_valid), 32'(!jz && !jn && !hlt));
    check_eq("exec_instr", 32'(instr_out), 32'(ins));
    check_eq("exec_jizr", 32'(arith_jizr), 32'(jz));
    check_eq("exec_jnzr", 32'(arith_jnzr), 32'(jn));
    check_eq("exec_v", 32'(arith_v), 32'(v));
    check_eq("exec_x", 32'(arith_x), 32'(mpc));
    check_eq("exec_req", 32'(imem_req), 0);
    check_eq("exec_done", 32'(done), 0);
    tick();
    start    = 1'b0;
    imem_ack = 1'b0;
    if (!hlt) mpc = taken ? tgt : 8'(mpc + 8'd1);
    check_eq("pc_after", 32'(pc), 32'(mpc));
    check_eq("done_after", 32'(done), 32'(hlt));
    check_eq("req_after", 32'(imem_req), 32'(!hlt));
  endtask

  task automatic halt_idle(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'($urandom);
      instr    = 9'($urandom);
      @(negedge clk);
      check_eq("halt_done", 32'(done), 1);
      check_eq("halt_pc", 32'(pc), 32'(mpc));
      check_eq("halt_req", 32'(imem_req), 0);
      check_eq("halt_valid", 32'(instr_valid), 0);
      tick();
    end
  endtask

  task automatic walk_to(input logic [7:0] target);
    while (mpc != target) run_instr(gen(0), 1'($urandom), 0);
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    check_eq("rst_pc", 32'(pc), 0);
    check_eq("rst_req", 32'(imem_req), 0);
    check_eq("rst_valid", 32'(instr_valid), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_jump", 32'({arith_jizr, arith_jnzr}), 0);
    check_eq("rst_instr", 32'(instr_out), 0);
    tick();
    tick();
    reset = 1'b0;
    imem_ack = 1'b1;
    tick();
    check_eq("idle_req", 32'(imem_req), 0);
    imem_ack = 1'b0;

    do_start();
    run_instr(9'h045, 1'b0, 0);
    check_eq("first_pc", 32'(pc), 1);

    walk_to(8'h10);
    run_instr(9'b110_000_011, 1'b1, 0);
    check_eq("jizr_taken", 32'(pc), 32'h16);
    run_instr(9'h000, 1'b0, 0);
    halt_idle(2);
    do_start();
    walk_to(8'h10);
    run_instr(9'b110_000_011, 1'b0, 0);
    check_eq("jizr_not_taken", 32'(pc), 32'h11);

    run_instr(gen(0), 1'b0, 5);

    walk_to(8'hFC);
    run_instr(9'b111_000_111, 1'b0, 0);
    check_eq("jnzr_wrap", 32'(pc), 32'h0A);
    walk_to(8'hFF);
    run_instr(gen(0), 1'b1, 0);
    check_eq("inc_wrap", 32'(pc), 32'h00);

    run_instr(gen(1), 1'b0, 1);
    run_instr(9'h000, 1'b1, 0);
    halt_idle(3);
    do_start();

    // Reset in FETCH while ack lands on the same edge.
    run_instr(gen(0), 1'b0, 0);
    run_instr(gen(0), 1'b0, 0);
    imem_ack = 1'b1;
    instr    = 9'h045;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("rstf_req", 32'(imem_req), 0);
    check_eq("rstf_pc", 32'(pc), 0);
    tick();
    check_eq("rstf_valid", 32'(instr_valid), 0);
    check_eq("rstf_pc2", 32'(pc), 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rstf_idle", 32'(imem_req), 0);
    check_eq("rstf_valid2", 32'(instr_valid), 0);
    tick();
    imem_ack = 1'b0;
    do_start();

    // Reset in EXEC drops the pending valid pulse immediately.
    run_instr(gen(0), 1'b0, 0);
    imem_ack = 1'b1;
    instr    = gen(0);
    tick();
    imem_ack = 1'b0;
    @(negedge clk);
    check_eq("rste_valid_pre", 32'(instr_valid), 1);
    #2 reset = 1'b1;
    #1;
    check_eq("rste_valid", 32'(instr_valid), 0);
    check_eq("rste_pc", 32'(pc), 0);
    tick();
    check_eq("rste_req", 32'(imem_req), 0);
    reset = 1'b0;
    tick();
    do_start();

    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom % 16);
      if (r < 9)       run_instr(gen(0), 1'($urandom), int'($urandom % 3));
      else if (r < 12) run_instr(gen(1), 1'($urandom), int'($urandom % 3));
      else if (r < 15) run_instr(gen(2), 1'($urandom), int'($urandom % 3));
      else begin
        run_instr(9'h000, 1'($urandom), int'($urandom % 3));
        halt_idle(int'($urandom % 3) + 1);
        do_start();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
